// File: rtl/load_store_unit_if.sv
// Core request/response channel and word-indexed data-memory port of the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic [31:0] mem_writeData;
  logic        mem_write;
  logic [31:0] mem_readData;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_readData,
    input  req_ready, resp_valid, resp_rdata, resp_error, mem_address, mem_writeData, mem_write
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_readData,
    output req_ready, resp_valid, resp_rdata, resp_error, mem_address, mem_writeData, mem_write
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte-addressed core requests to a word-indexed memory with lane select,
// load extension, read-modify-write sub-word stores and alignment/range error detection.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 100
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned IDXW = XLEN - 2;
  localparam logic [1:0]  SZ_B = 2'b00;
  localparam logic [1:0]  SZ_H = 2'b01;
  localparam logic [1:0]  SZ_W = 2'b10;
  localparam logic [1:0]  SZ_X = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RMW_RD, S_WRITE, S_RESP} state_e;

  state_e          state_q, state_d;
  logic            write_q, write_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] merge_q, merge_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  logic            accept;
  logic            req_err;
  logic            mem_active;
  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] store_word;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;

  assign accept  = bus.req_valid && (state_q == S_IDLE);
  assign req_err = (bus.req_size == SZ_X)
                || ((bus.req_size == SZ_H) && bus.req_addr[0])
                || ((bus.req_size == SZ_W) && (bus.req_addr[1:0] != 2'b00))
                || (bus.req_addr[XLEN-1:2] >= IDXW'(MEM_WORDS));

  // Lane select and extension of the addressed load data
  assign lane_b = bus.mem_readData[{addr_q[1:0], 3'b000} +: 8];
  assign lane_h = bus.mem_readData[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    load_val = bus.mem_readData;
    case (size_q)
      SZ_B:    load_val = uns_q ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      SZ_H:    load_val = uns_q ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_val = bus.mem_readData;
    endcase
  end

  // Replace only the target lanes of the previously read word
  always_comb begin
    store_word = merge_q;
    case (size_q)
      SZ_B:    store_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      SZ_H:    store_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: store_word = wdata_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          write_d = bus.req_write;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          merge_d = bus.req_wdata;
          rdata_d = '0;
          err_d   = req_err;
          if (req_err)                   state_d = S_RESP;
          else if (!bus.req_write)       state_d = S_LOAD;
          else if (bus.req_size == SZ_W) state_d = S_WRITE;
          else                           state_d = S_RMW_RD;
        end
      end
      S_LOAD: begin
        rdata_d = load_val;
        state_d = S_RESP;
      end
      S_RMW_RD: begin
        merge_d = bus.mem_readData;
        state_d = S_WRITE;
      end
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Memory port decoded purely from the state register so reset drops it immediately
  assign mem_active        = (state_q == S_LOAD) || (state_q == S_RMW_RD) || (state_q == S_WRITE);
  assign bus.req_ready     = (state_q == S_IDLE);
  assign bus.resp_valid    = (state_q == S_RESP);
  assign bus.resp_rdata    = rdata_q;
  assign bus.resp_error    = err_q;
  assign bus.mem_write     = (state_q == S_WRITE) && write_q;
  assign bus.mem_address   = mem_active ? {2'b00, addr_q[XLEN-1:2]} : '0;
  assign bus.mem_writeData = (state_q == S_WRITE) ? store_word : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed bench for load_store_unit against a byte-level memory reference model.
`timescale 1ns/1ps
module tb_load_store_unit;
  localparam int unsigned MEM_WORDS = 100;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   wr_cnt = 0;
  int   nz_cnt = 0;

  logic [31:0] mem     [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];

  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Data memory: combinational read, write on the rising edge
  assign bus.mem_readData = (bus.mem_address < MEM_WORDS) ? mem[7'(bus.mem_address)] : 32'h0;

  always @(posedge clk)
    if (bus.mem_write && (bus.mem_address < MEM_WORDS))
      mem[7'(bus.mem_address)] <= bus.mem_writeData;

  always @(negedge clk) begin
    if (bus.mem_write) wr_cnt++;
    if (bus.mem_address != 32'h0) nz_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference: expected error, load result and latency; stores update ref_mem byte by byte
  task automatic model(input logic wr, input logic [1:0] sz, input logic un, input logic [31:0] a,
                       input logic [31:0] wd, output logic err, output logic [31:0] rd, output int lat);
    int nb;
    int off;
    int idx;
    logic [31:0] w;
    nb  = 1 << sz;
    off = int'(a[1:0]);
    err = (sz == 2'b11) || ((off % nb) != 0) || ((a >> 2) >= 32'(MEM_WORDS));
    rd  = 32'h0;
    lat = 1;
    if (!err) begin
      idx = int'(a >> 2);
      w   = ref_mem[idx];
      if (!wr) begin
        for (int k = 0; k < nb; k++) rd[8*k +: 8] = w[8*(off+k) +: 8];
        if (!un && (nb < 4) && rd[8*nb-1])
          for (int k = nb; k < 4; k++) rd[8*k +: 8] = 8'hFF;
        lat = 2;
      end else begin
        for (int k = 0; k < nb; k++) w[8*(off+k) +: 8] = wd[8*k +: 8];
        ref_mem[idx] = w;
        lat = (nb == 4) ? 2 : 3;
      end
    end
  endtask

  task automatic run_req(input string tag, input logic wr, input logic [1:0] sz, input logic un,
                         input logic [31:0] a, input logic [31:0] wd);
    logic        e_err;
    logic [31:0] e_rd;
    int          e_lat;
    int          lat;
    int          w0;
    int          n0;
    model(wr, sz, un, a, wd, e_err, e_rd, e_lat);
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = un;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    check($sformatf("%s/ready", tag), 32'(bus.req_ready), 32'd1);
    w0 = wr_cnt;
    n0 = nz_cnt;
    @(posedge clk); #1;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'($urandom);
    bus.req_size     = 2'($urandom);
    bus.req_unsigned = 1'($urandom);
    bus.req_addr     = $urandom;
    bus.req_wdata    = $urandom;
    lat = 1;
    if (!e_err) begin
      check($sformatf("%s/clr_rd", tag), bus.resp_rdata, 32'h0);
      check($sformatf("%s/clr_err", tag), 32'(bus.resp_error), 32'd0);
    end
    while (!bus.resp_valid && lat < 8) begin
      check($sformatf("%s/busy", tag), 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("%s/lat", tag), 32'(lat), 32'(e_lat));
    check($sformatf("%s/resp_ready", tag), 32'(bus.req_ready), 32'd0);
    check($sformatf("%s/err", tag), 32'(bus.resp_error), 32'(e_err));
    check($sformatf("%s/rdata", tag), bus.resp_rdata, e_rd);
    check($sformatf("%s/wr", tag), 32'(wr_cnt - w0), (wr && !e_err) ? 32'd1 : 32'd0);
    if (e_err) check($sformatf("%s/addr0", tag), 32'(nz_cnt - n0), 32'd0);
    if ((a >> 2) < 32'(MEM_WORDS))
      check($sformatf("%s/mem", tag), mem[7'(a >> 2)], ref_mem[7'(a >> 2)]);
    @(posedge clk); #1;
    check($sformatf("%s/pulse", tag), 32'(bus.resp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] v;
    int          pulses;
    int          accepts;
    logic [1:0]  sz;
    logic [31:0] a;

    rst              = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    for (int i = 0; i < int'(MEM_WORDS); i++) begin
      v          = $urandom;
      mem[i]     = v;
      ref_mem[i] = v;
    end

    repeat (2) @(posedge clk);
    #1;
    check("rst/ready", 32'(bus.req_ready), 32'd1);
    check("rst/resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst/mem_write", 32'(bus.mem_write), 32'd0);
    check("rst/mem_address", bus.mem_address, 32'h0);
    check("rst/rdata", bus.resp_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Reset asserted while a word store is in its write cycle
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h14;
    bus.req_wdata = ~ref_mem[5];
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("rstw/in_write", 32'(bus.mem_write), 32'd1);
    rst = 1'b0;
    #1;
    check("rstw/mem_write", 32'(bus.mem_write), 32'd0);
    check("rstw/mem_address", bus.mem_address, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstw/ready", 32'(bus.req_ready), 32'd1);
    check("rstw/resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rstw/mem", mem[5], ref_mem[5]);
    @(posedge clk); #1;
    check("rstw/no_resp", 32'(bus.resp_valid), 32'd0);

    run_req("sw", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    check("sw/const", mem[4], 32'hDEADBEEF);
    run_req("lw", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("lw/const", bus.resp_rdata, 32'hDEADBEEF);

    run_req("sw2", 1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01);
    run_req("lb", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    check("lb/const", bus.resp_rdata, 32'hFFFFFF80);
    run_req("lbu", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    check("lbu/const", bus.resp_rdata, 32'h00000080);
    run_req("lh0", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
    check("lh0/const", bus.resp_rdata, 32'h00007F01);
    run_req("lh2", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    check("lh2/const", bus.resp_rdata, 32'hFFFF80FF);

    run_req("sw3", 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
    run_req("sb", 1'b1, 2'b00, 1'b0, 32'h11, 32'h555555AA);
    check("sb/const", mem[4], 32'h1122AA44);
    run_req("sh", 1'b1, 2'b01, 1'b0, 32'h12, 32'h1234BEEF);
    check("sh/const", mem[4], 32'hBEEFAA44);

    run_req("e_lw", 1'b0, 2'b10, 1'b0, 32'h11, 32'h0);
    run_req("e_sh", 1'b1, 2'b01, 1'b0, 32'h13, 32'hFFFF);
    run_req("e_sz", 1'b1, 2'b11, 1'b0, 32'h10, 32'h12345678);
    run_req("e_rng", 1'b0, 2'b10, 1'b0, 32'd400, 32'h0);
    run_req("e_srng", 1'b1, 2'b10, 1'b0, 32'd400, 32'hCAFEF00D);
    check("e/const", mem[4], 32'hBEEFAA44);

    // Valid held high across three back-to-back loads, address disturbed while busy
    bus.req_valid    = 1'b1;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h10;
    pulses  = 0;
    accepts = 0;
    repeat (16) begin
      @(negedge clk);
      if (accepts == 3)       bus.req_valid = 1'b0;
      else if (bus.req_ready) accepts++;
      else                    bus.req_addr = bus.resp_valid ? 32'h10 : 32'h51;
      @(posedge clk); #1;
      if (bus.resp_valid) begin
        pulses++;
        check("hs/rdata", bus.resp_rdata, 32'hBEEFAA44);
        check("hs/err", 32'(bus.resp_error), 32'd0);
        check("hs/ready", 32'(bus.req_ready), 32'd0);
      end
    end
    check("hs/pulses", 32'(pulses), 32'd3);
    bus.req_valid = 1'b0;

    for (int n = 0; n < 300; n++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = ($urandom_range(0, 19) == 0) ? $urandom
                                        : ((32'($urandom_range(0, 104)) << 2) | 32'($urandom_range(0, 3)));
      run_req($sformatf("rnd%0d", n), 1'($urandom), sz, 1'($urandom), a, $urandom);
    end

    for (int i = 0; i < int'(MEM_WORDS); i++)
      check($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
